// File: rtl/pcileech_tlps128_dw_serializer.sv
// Unpacks 128-bit TLP beats (up to 4 DWs, keep-qualified) into a 32-bit DW stream
// with first/last framing, sticky keep/framing error flags and a completed-TLP counter.
module pcileech_tlps128_dw_serializer #(
   parameter int unsigned PKT_CNT_W = 16
) (
   input  logic                 clk_pcie,
   input  logic                 rst_n,
   input  logic [127:0]         s_tdata,
   input  logic [3:0]           s_tkeepdw,
   input  logic                 s_tlast,
   input  logic                 s_tfirst,
   input  logic                 s_tvalid,
   output logic                 s_tready,
   output logic [31:0]          m_dw_data,
   output logic                 m_dw_first,
   output logic                 m_dw_last,
   output logic                 m_dw_valid,
   input  logic                 m_dw_ready,
   output logic                 err_keep,
   output logic                 err_frame,
   output logic [PKT_CNT_W-1:0] pkt_count
);

   typedef enum logic {StEmpty, StShift} state_e;

   state_e                 state_q, state_d;
   logic [127:0]           hold_data_q, hold_data_d;
   logic                   hold_first_q, hold_first_d;
   logic                   hold_last_q, hold_last_d;
   logic [1:0]             idx_q, idx_d;
   logic [1:0]             lastidx_q, lastidx_d;
   logic                   in_pkt_q, in_pkt_d;
   logic                   err_keep_q, err_keep_d;
   logic                   err_frame_q, err_frame_d;
   logic [PKT_CNT_W-1:0]   pkt_count_q, pkt_count_d;

   logic       keep_legal;
   logic [1:0] keep_lastidx;
   logic       at_last;
   logic       beat_acc;
   logic       dw_xfer;

   always_comb begin
      keep_legal   = 1'b1;
      keep_lastidx = 2'd0;
      case (s_tkeepdw)
         4'b0001: keep_lastidx = 2'd0;
         4'b0011: keep_lastidx = 2'd1;
         4'b0111: keep_lastidx = 2'd2;
         4'b1111: keep_lastidx = 2'd3;
         default: keep_legal   = 1'b0;
      endcase
   end

   assign at_last  = (idx_q == lastidx_q);
   // Ready while in reset is forced low; otherwise ready when the held beat is retiring.
   assign s_tready = rst_n && ((state_q == StEmpty) || (m_dw_ready && at_last));
   assign beat_acc = s_tvalid && s_tready;
   assign dw_xfer  = (state_q == StShift) && m_dw_ready;

   assign m_dw_valid = (state_q == StShift);
   assign m_dw_data  = m_dw_valid ? hold_data_q[{idx_q, 5'b0} +: 32] : 32'd0;
   assign m_dw_first = m_dw_valid && hold_first_q && (idx_q == 2'd0);
   assign m_dw_last  = m_dw_valid && hold_last_q && at_last;
   assign err_keep   = err_keep_q;
   assign err_frame  = err_frame_q;
   assign pkt_count  = pkt_count_q;

   always_comb begin
      state_d      = state_q;
      hold_data_d  = hold_data_q;
      hold_first_d = hold_first_q;
      hold_last_d  = hold_last_q;
      idx_d        = idx_q;
      lastidx_d    = lastidx_q;
      in_pkt_d     = in_pkt_q;
      err_keep_d   = err_keep_q;
      err_frame_d  = err_frame_q;
      pkt_count_d  = pkt_count_q;

      if (dw_xfer) begin
         if (!at_last) begin
            idx_d = idx_q + 2'd1;
         end else begin
            state_d = StEmpty;
         end
         if (m_dw_last) begin
            pkt_count_d = pkt_count_q + 1'b1;
         end
      end

      // Illegal beats are swallowed whole and do not touch packet framing state.
      if (beat_acc) begin
         if (keep_legal) begin
            state_d      = StShift;
            hold_data_d  = s_tdata;
            hold_first_d = s_tfirst;
            hold_last_d  = s_tlast;
            idx_d        = 2'd0;
            lastidx_d    = keep_lastidx;
            if ((s_tkeepdw != 4'b1111 && !s_tlast) || (s_tfirst == in_pkt_q)) begin
               err_frame_d = 1'b1;
            end
            if (s_tlast) begin
               in_pkt_d = 1'b0;
            end else if (s_tfirst) begin
               in_pkt_d = 1'b1;
            end
         end else begin
            err_keep_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_pcie or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StEmpty;
         hold_data_q  <= '0;
         hold_first_q <= 1'b0;
         hold_last_q  <= 1'b0;
         idx_q        <= 2'd0;
         lastidx_q    <= 2'd0;
         in_pkt_q     <= 1'b0;
         err_keep_q   <= 1'b0;
         err_frame_q  <= 1'b0;
         pkt_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         hold_data_q  <= hold_data_d;
         hold_first_q <= hold_first_d;
         hold_last_q  <= hold_last_d;
         idx_q        <= idx_d;
         lastidx_q    <= lastidx_d;
         in_pkt_q     <= in_pkt_d;
         err_keep_q   <= err_keep_d;
         err_frame_q  <= err_frame_d;
         pkt_count_q  <= pkt_count_d;
      end
   end

endmodule

// File: tb/tb_pcileech_tlps128_dw_serializer.sv
// Bench for the 128->32 DW serializer: a queue of expected DWs drives all checks,
// with directed framing/reset scenarios followed by a randomized run.
module tb_pcileech_tlps128_dw_serializer;

   localparam int unsigned CntW = 4;

   logic            clk_pcie = 1'b0;
   logic            rst_n;
   logic [127:0]    s_tdata;
   logic [3:0]      s_tkeepdw;
   logic            s_tlast, s_tfirst, s_tvalid, s_tready;
   logic [31:0]     m_dw_data;
   logic            m_dw_first, m_dw_last, m_dw_valid, m_dw_ready;
   logic            err_keep, err_frame;
   logic [CntW-1:0] pkt_count;

   pcileech_tlps128_dw_serializer #(.PKT_CNT_W(CntW)) dut (
      .clk_pcie   (clk_pcie),
      .rst_n      (rst_n),
      .s_tdata    (s_tdata),
      .s_tkeepdw  (s_tkeepdw),
      .s_tlast    (s_tlast),
      .s_tfirst   (s_tfirst),
      .s_tvalid   (s_tvalid),
      .s_tready   (s_tready),
      .m_dw_data  (m_dw_data),
      .m_dw_first (m_dw_first),
      .m_dw_last  (m_dw_last),
      .m_dw_valid (m_dw_valid),
      .m_dw_ready (m_dw_ready),
      .err_keep   (err_keep),
      .err_frame  (err_frame),
      .pkt_count  (pkt_count)
   );

   always #5 clk_pcie = ~clk_pcie;

   typedef struct {
      logic [31:0] d;
      logic        f;
      logic        l;
   } dw_t;

   dw_t             exp_q[$];
   logic [CntW-1:0] m_pkt;
   logic            m_err_keep, m_err_frame, m_in_pkt;
   int              n_checks = 0;
   int              n_fail   = 0;
   int unsigned     cyc      = 0;
   logic            toggle_rdy = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Number of DWs a keep pattern carries; 0 means illegal (must be contiguous from DW0).
   function automatic int keep_dws(input logic [3:0] k);
      int n = $countones(k);
      logic [4:0] mask = (5'd1 << n) - 5'd1;
      if (n > 0 && {1'b0, k} == mask) return n;
      return 0;
   endfunction

   task automatic model_clear();
      exp_q.delete();
      m_pkt       = '0;
      m_err_keep  = 1'b0;
      m_err_frame = 1'b0;
      m_in_pkt    = 1'b0;
   endtask

   // One clock: drive inputs, check at negedge, advance the model at posedge.
   task automatic step(input logic v, input logic [127:0] d, input logic [3:0] k,
                       input logic f, input logic l, input logic r, output logic acc);
      logic exp_valid, exp_rdy, xfer;
      int   n;
      dw_t  x;
      s_tvalid = v; s_tdata = d; s_tkeepdw = k; s_tfirst = f; s_tlast = l; m_dw_ready = r;
      @(negedge clk_pcie);
      exp_valid = (exp_q.size() != 0);
      exp_rdy   = (exp_q.size() == 0) || (exp_q.size() == 1 && r);
      check("s_tready", {31'd0, s_tready}, {31'd0, exp_rdy});
      check("m_dw_valid", {31'd0, m_dw_valid}, {31'd0, exp_valid});
      check("err_keep", {31'd0, err_keep}, {31'd0, m_err_keep});
      check("err_frame", {31'd0, err_frame}, {31'd0, m_err_frame});
      check("pkt_count", {28'd0, pkt_count}, {28'd0, m_pkt});
      if (exp_valid) begin
         check("m_dw_data", m_dw_data, exp_q[0].d);
         check("m_dw_first", {31'd0, m_dw_first}, {31'd0, exp_q[0].f});
         check("m_dw_last", {31'd0, m_dw_last}, {31'd0, exp_q[0].l});
      end
      acc  = v && exp_rdy;
      xfer = exp_valid && r;
      @(posedge clk_pcie);
      cyc++;
      if (xfer) begin
         x = exp_q.pop_front();
         if (x.l) m_pkt = m_pkt + 1'b1;
      end
      if (acc) begin
         n = keep_dws(k);
         if (n == 0) begin
            m_err_keep = 1'b1;
         end else begin
            if ((n != 4 && !l) || (f && m_in_pkt) || (!f && !m_in_pkt)) m_err_frame = 1'b1;
            if (l) m_in_pkt = 1'b0;
            else if (f) m_in_pkt = 1'b1;
            for (int i = 0; i < n; i++) begin
               x.d = d[32*i +: 32];
               x.f = f && (i == 0);
               x.l = l && (i == n - 1);
               exp_q.push_back(x);
            end
         end
      end
      #1;
   endtask

   function automatic logic cur_rdy();
      return toggle_rdy ? cyc[0] : 1'b1;
   endfunction

   task automatic send_beat(input logic [127:0] d, input logic [3:0] k,
                            input logic f, input logic l);
      logic acc = 1'b0;
      int   tries = 0;
      while (!acc && tries < 20) begin
         step(1'b1, d, k, f, l, cur_rdy(), acc);
         tries++;
      end
      if (!acc) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      logic acc;
      int   tries = 0;
      while (exp_q.size() != 0 && tries < 20) begin
         step(1'b0, '0, 4'b0, 1'b0, 1'b0, cur_rdy(), acc);
         tries++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 32'd0, 32'd1);
      step(1'b0, '0, 4'b0, 1'b0, 1'b0, 1'b1, acc);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      model_clear();
      check("rst_valid", {31'd0, m_dw_valid}, 32'd0);
      check("rst_tready", {31'd0, s_tready}, 32'd0);
      @(negedge clk_pcie);
      rst_n = 1'b1;
      @(posedge clk_pcie);
      #1;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic        acc;
      logic [3:0]  k;
      logic        f, l;
      logic [3:0]  legal_k [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

      rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeepdw = '0;
      s_tfirst = 1'b0; s_tlast = 1'b0; m_dw_ready = 1'b0;
      model_clear();
      #12;
      check("init_valid", {31'd0, m_dw_valid}, 32'd0);
      check("init_data", m_dw_data, 32'd0);
      check("init_first", {31'd0, m_dw_first}, 32'd0);
      check("init_last", {31'd0, m_dw_last}, 32'd0);
      check("init_tready", {31'd0, s_tready}, 32'd0);
      check("init_errs", {30'd0, err_keep, err_frame}, 32'd0);
      check("init_pkt", {28'd0, pkt_count}, 32'd0);
      @(negedge clk_pcie);
      rst_n = 1'b1;
      @(posedge clk_pcie);
      #1;

      // Single 3-DW completion
      send_beat(rnd128(), 4'b0111, 1'b1, 1'b1);
      drain();
      check("t1_pkt", {28'd0, pkt_count}, 32'd1);

      // 6-DW TLP across two beats, no bubble
      send_beat(rnd128(), 4'b1111, 1'b1, 1'b0);
      send_beat(rnd128(), 4'b0011, 1'b0, 1'b1);
      drain();
      check("t2_pkt", {28'd0, pkt_count}, 32'd2);

      // Stalling sink
      toggle_rdy = 1'b1;
      send_beat(rnd128(), 4'b1111, 1'b1, 1'b1);
      drain();
      toggle_rdy = 1'b0;
      check("t3_pkt", {28'd0, pkt_count}, 32'd3);

      // Illegal keep dropped, then normal TLP
      do_reset();
      send_beat(rnd128(), 4'b0101, 1'b1, 1'b1);
      step(1'b0, '0, 4'b0, 1'b0, 1'b0, 1'b1, acc);
      check("t4_err_keep", {31'd0, err_keep}, 32'd1);
      check("t4_no_dw", {31'd0, m_dw_valid}, 32'd0);
      send_beat(rnd128(), 4'b0001, 1'b1, 1'b1);
      drain();
      check("t4_pkt", {28'd0, pkt_count}, 32'd1);

      // tfirst while in a packet
      do_reset();
      send_beat(rnd128(), 4'b1111, 1'b1, 1'b0);
      send_beat(rnd128(), 4'b0011, 1'b1, 1'b1);
      drain();
      check("t5_err_frame", {31'd0, err_frame}, 32'd1);
      check("t5_pkt", {28'd0, pkt_count}, 32'd1);

      // Asynchronous reset mid-beat
      do_reset();
      send_beat(rnd128(), 4'b1111, 1'b1, 1'b1);
      step(1'b0, '0, 4'b0, 1'b0, 1'b0, 1'b1, acc);
      step(1'b0, '0, 4'b0, 1'b0, 1'b0, 1'b1, acc);
      rst_n = 1'b0;
      #1;
      check("t6_valid", {31'd0, m_dw_valid}, 32'd0);
      check("t6_data", m_dw_data, 32'd0);
      check("t6_flags", {30'd0, m_dw_first, m_dw_last}, 32'd0);
      check("t6_tready", {31'd0, s_tready}, 32'd0);
      check("t6_pkt", {28'd0, pkt_count}, 32'd0);
      model_clear();
      @(negedge clk_pcie);
      rst_n = 1'b1;
      @(posedge clk_pcie);
      #1;
      send_beat(rnd128(), 4'b1111, 1'b1, 1'b1);
      drain();
      check("t6_pkt_after", {28'd0, pkt_count}, 32'd1);

      // Randomized traffic; counter width is small so wrap is exercised
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(15) == 0) k = 4'($urandom);
         else k = legal_k[$urandom_range(3)];
         f = m_in_pkt ? ($urandom_range(15) == 0) : ($urandom_range(15) != 0);
         l = (k != 4'b1111) ? ($urandom_range(15) != 0) : 1'($urandom);
         step($urandom_range(3) != 0, rnd128(), k, f, l, $urandom_range(2) != 0, acc);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
